// File: rtl/spi_reg_pkg.sv
// Shared constants, register map and FSM state type for the SPI register bridge.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned NUM_OUT_REGS = 5;

  localparam logic [CNT_W-1:0] CNT_MAX   = 5'd17;
  localparam logic [CNT_W-1:0] CNT_FRAME = 5'd16;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_PWM_LO    = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_PWM_HI    = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer with a configurable synchronous reset value.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI target that receives 16-bit write frames (R/W, 7-bit address, 8-bit data) and
// updates a small bank of 8-bit control registers in the clk domain.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic sclk_s, copi_s, ncs_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi), .q(copi_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(ncs), .q(ncs_s)
  );

  logic                   sclk_prev_q, ncs_prev_q, copi_q;
  logic                   sclk_rise_q, ncs_rise_q, ncs_fall_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   armed_q;

  // A fall is only trusted once the synchronizers hold real pin values and ncs has been
  // seen high, so a reset taken mid-frame cannot look like a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      copi_q      <= 1'b0;
      sclk_rise_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      copi_q      <= copi_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      ncs_rise_q  <= ncs_s & ~ncs_prev_q;
      ncs_fall_q  <= ~ncs_s & ncs_prev_q & armed_q;
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_q | (ncs_s & flush_q[SYNC_STAGES-1]);
    end
  end

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr;
  logic                    do_write, do_err;

  assign addr = shift_q[14:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    do_write = 1'b0;
    do_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall_q) begin
          state_d = StShift;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (sclk_rise_q) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_q};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
        end
        if (ncs_rise_q) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        if (cnt_q != CNT_FRAME) begin
          do_err = 1'b1;
        end else if (shift_q[FRAME_BITS-1]) begin
          if (32'(addr) < NUM_REGS) do_write = 1'b1;
          else                      do_err   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [7:0] regs_q [NUM_OUT_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_OUT_REGS); i++) regs_q[i] <= 8'h00;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= do_write;
      frame_err <= do_err;
      if (do_write) begin
        case (addr)
          ADDR_EN_OUT_LO: regs_q[0] <= shift_q[7:0];
          ADDR_EN_OUT_HI: regs_q[1] <= shift_q[7:0];
          ADDR_PWM_LO:    regs_q[2] <= shift_q[7:0];
          ADDR_PWM_HI:    regs_q[3] <= shift_q[7:0];
          ADDR_PWM_DUTY:  regs_q[4] <= shift_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge at default parameters.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe, frame_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic [39:0] regs_now();
    return {r4, r3, r2, r1, r0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    @(negedge clk);
    ncs = 1'b0;
    tick(4);
  endtask

  task automatic spi_bits(input logic [16:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_stop();
    tick(4);
    ncs = 1'b1;
    tick(10);
  endtask

  task automatic send(input logic [16:0] v, input int n);
    spi_start();
    spi_bits(v, n);
    spi_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    tick(3);
    checks++;
    if (regs_now() !== 40'h0) begin
      errors++; $display("FAIL reset_regs: got %h want %h", regs_now(), 40'h0);
    end
    checks++;
    if ({wr_strobe, frame_err} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses: got %b want 00", {wr_strobe, frame_err});
    end
    rst = 1'b0;
    tick(6);
  endtask

  task automatic test_latency();
    int wr0, er0;
    wr0 = wr_cnt; er0 = err_cnt;
    spi_start();
    spi_bits(17'h08480, 16);
    tick(4);
    ncs = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r4, wr_strobe} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL lat_early: got duty=%h strobe=%b want 00/0", r4, wr_strobe);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({r4, wr_strobe} !== {8'h80, 1'b1}) begin
      errors++; $display("FAIL lat_e4: got duty=%h strobe=%b want 80/1", r4, wr_strobe);
    end
    tick(10);
    checks++;
    if (regs_now() !== 40'h80_00000000) begin
      errors++; $display("FAIL lat_regs: got %h want %h", regs_now(), 40'h80_00000000);
    end
    checks++;
    if ((wr_cnt - wr0) != 1 || (err_cnt - er0) != 0) begin
      errors++; $display("FAIL lat_pulses: got wr=%0d err=%0d want 1/0", wr_cnt - wr0, err_cnt - er0);
    end
  endtask

  task automatic test_back_to_back();
    int wr0, er0;
    wr0 = wr_cnt; er0 = err_cnt;
    send(17'h080F0, 16);
    send(17'h081AA, 16);
    send(17'h08255, 16);
    send(17'h0830F, 16);
    checks++;
    if (regs_now() !== 40'h80_0F_55_AA_F0) begin
      errors++; $display("FAIL b2b_regs: got %h want %h", regs_now(), 40'h80_0F_55_AA_F0);
    end
    checks++;
    if ((wr_cnt - wr0) != 4 || (err_cnt - er0) != 0) begin
      errors++; $display("FAIL b2b_pulses: got wr=%0d err=%0d want 4/0", wr_cnt - wr0, err_cnt - er0);
    end
  endtask

  task automatic test_bad_addr();
    int wr0, er0;
    wr0 = wr_cnt; er0 = err_cnt;
    send(17'h085FF, 16);
    checks++;
    if (regs_now() !== 40'h80_0F_55_AA_F0) begin
      errors++; $display("FAIL badaddr_regs: got %h want %h", regs_now(), 40'h80_0F_55_AA_F0);
    end
    checks++;
    if ((wr_cnt - wr0) != 0 || (err_cnt - er0) != 1) begin
      errors++; $display("FAIL badaddr_pulses: got wr=%0d err=%0d want 0/1", wr_cnt - wr0, err_cnt - er0);
    end
  endtask

  task automatic test_frame_len();
    int wr0, er0;
    wr0 = wr_cnt; er0 = err_cnt;
    send(17'h0404C, 15);
    checks++;
    if (r0 !== 8'hF0 || (err_cnt - er0) != 1 || (wr_cnt - wr0) != 0) begin
      errors++; $display("FAIL short_frame: got r0=%h err=%0d wr=%0d want F0/1/0", r0, err_cnt - er0, wr_cnt - wr0);
    end
    wr0 = wr_cnt; er0 = err_cnt;
    send(17'h18099, 17);
    checks++;
    if (r0 !== 8'hF0 || (err_cnt - er0) != 1 || (wr_cnt - wr0) != 0) begin
      errors++; $display("FAIL long_frame: got r0=%h err=%0d wr=%0d want F0/1/0", r0, err_cnt - er0, wr_cnt - wr0);
    end
    wr0 = wr_cnt; er0 = err_cnt;
    send(17'h00012, 16);
    checks++;
    if (regs_now() !== 40'h80_0F_55_AA_F0 || (err_cnt - er0) != 0 || (wr_cnt - wr0) != 0) begin
      errors++; $display("FAIL read_frame: got %h err=%0d wr=%0d want %h/0/0", regs_now(), err_cnt - er0, wr_cnt - wr0, 40'h80_0F_55_AA_F0);
    end
  endtask

  task automatic test_reset_midframe();
    int wr0, er0;
    spi_start();
    spi_bits(17'h00084, 8);
    rst = 1'b1;
    tick(3);
    checks++;
    if (regs_now() !== 40'h0 || {wr_strobe, frame_err} !== 2'b00) begin
      errors++; $display("FAIL midrst_regs: got %h pulses=%b want 0/00", regs_now(), {wr_strobe, frame_err});
    end
    rst = 1'b0;
    tick(4);
    wr0 = wr_cnt; er0 = err_cnt;
    spi_bits(17'h00033, 8);
    spi_stop();
    checks++;
    if (regs_now() !== 40'h0 || (wr_cnt - wr0) != 0 || (err_cnt - er0) != 0) begin
      errors++; $display("FAIL midrst_tail: got %h wr=%0d err=%0d want 0/0/0", regs_now(), wr_cnt - wr0, err_cnt - er0);
    end
    wr0 = wr_cnt;
    send(17'h08411, 16);
    checks++;
    if (regs_now() !== 40'h11_00000000 || (wr_cnt - wr0) != 1) begin
      errors++; $display("FAIL midrst_next: got %h wr=%0d want %h/1", regs_now(), wr_cnt - wr0, 40'h11_00000000);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_bad_addr();
    test_frame_len();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
